pucch1_occ_phase_gen: RTL and testbench
=======================================

// Module: pucch1_occ_phase_gen
// PURPOSE
//  Generates the PUCCH format 1 time-domain OCC phase sequence w_i(m) (TS 38.211 Tbl 6.3.2.4.1-2)
//  for all N_SF = 1..7 and up to two frequency hops, one element per accepted request.
//  Phase is output in units of 1/PHASE_RES cycle. Sits between PUCCH1 control and the symbol rotator.
// PARAMETERS
//  PHASE_RES  420                  phase units per cycle; N_SF supported iff PHASE_RES % N_SF == 0
//  PHASE_W    $clog2(PHASE_RES)    width of o_wi_phi
// PORTS
//  clk             in   1        clock
//  rst             in   1        asynchronous, active-high reset
//  i_start         in   1        latch config, begin new sequence (aborts any running one)
//  i_next          in   1        consume current element when o_valid
//  i_nSF0          in   3        N_SF for hop 0 (1..7; 0 = invalid)
//  i_occi0         in   3        OCC index for hop 0
//  i_nSF1          in   3        N_SF for hop 1 (0 = no second hop)
//  i_occi1         in   3        OCC index for hop 1
//  i_phase_ofs     in   PHASE_W  phase offset, only with PUCCH1_OCC_PHASE_OFS_EN
//  o_wi_phi        out  PHASE_W  phase of current element, 0..PHASE_RES-1
//  o_m             out  3        element index within current hop
//  o_hop           out  1        hop of current element
//  o_last          out  1        current element is last of sequence
//  o_valid         out  1        element on outputs is valid
//  o_done          out  1        1-cycle pulse: sequence complete or rejected
//  o_is_supported  out  1        config of last i_start was accepted
//  o_busy          out  1        sequence in progress
// BEHAVIOUR
//  - Reset: all outputs 0; FSM to IDLE. Reset mid-sequence discards it, no o_done.
//  - FSM IDLE -> RUN on i_start (accepted config); RUN -> IDLE after last element consumed.
//  - i_start sampled at posedge t: config registered; o_valid=1 at t+1 with m=0, hop=0.
//  - Reject: nSF0==0, occi0>=nSF0, PHASE_RES%nSF0!=0, or (nSF1!=0 and occi1>=nSF1 or
//    PHASE_RES%nSF1!=0) -> o_is_supported=0, o_valid stays 0, o_done=1 at t+1. IDLE.
//  - o_is_supported updated at t+1 of every i_start, held until next i_start.
//  - Advance when o_valid && i_next at posedge; outputs registered, next element visible next
//    cycle; i_next held high -> one element per cycle. o_valid && !i_next -> all outputs hold.
//  - Order: hop0 m=0..nSF0-1, then hop1 m=0..nSF1-1 (if nSF1!=0). o_last on final element.
//  - Final element consumed -> o_valid=0, o_busy=0, o_done=1 for exactly one cycle.
//  - i_start while busy: restart at t+1 with new config; aborted sequence gives no o_done.
//  - i_start and i_next same cycle: i_start wins.
//  - phi(m): nSF==4 -> table {0000,0202,0022,0220}[occi]; else (occi*m) mod nSF via mod
//    accumulator (acc+=occi; if acc>=nSF acc-=nSF), no multiplier/divider.
//  - o_wi_phi = phi(m)*(PHASE_RES/nSF); PHASE_RES/nSF from constant table, result < PHASE_RES.
// CONFIGURATION
//  PUCCH1_OCC_PHASE_OFS_EN defined: port i_phase_ofs exists, latched on i_start;
//    o_wi_phi = (phase + ofs) mod PHASE_RES via single conditional subtract; ofs>=PHASE_RES
//    rejected as unsupported.
//  Not defined: port absent, offset is 0.
// STRUCTURE
//  - pucch1_occ_pkg: NSF_MAX=7, NSF_LCM=420, state enum, nSF=4 phi table, step-table function.
//  - Sub-module pucch1_occ_phi_gen: per-hop m counter + mod accumulator, giving phi, o_m, last.
//    Top holds FSM, hop sequencing, validation, scaling and output registers.
// TESTING
//  1. nSF0=4 occi0=1 nSF1=0, i_next=1 -> 0,210,0,210; o_last on 4th; o_done next cycle.
//  2. nSF0=7 occi0=3, nSF1=7 occi1=6 -> 0,180,360,120,300,60,240 | 0,360,300,240,180,120,60.
//  3. nSF0=3 occi0=2, i_next 1/0 alternating -> 0,280,140, each held while i_next=0.
//  4. nSF0=5 occi0=5 -> o_is_supported=0, no o_valid, o_done at t+1; PHASE_RES=24, nSF0=7 ->
//     rejected; PHASE_RES=24, nSF0=6 occi0=1 -> 0,4,8,12,16,20.
//  5. i_start mid-sequence (nSF0=6 -> nSF0=2 occi0=1) -> 0,210, one o_done; async rst
//     mid-sequence -> outputs 0 immediately, no o_done.
//  6. Macro on: ofs=400, nSF0=2 occi0=1 -> 400,190; ofs=420 -> rejected.

Source files
------------

// File: rtl/pucch1_occ_pkg.sv
// Shared types, constants and helper functions for the PUCCH format 1 OCC phase generator.
package pucch1_occ_pkg;

   localparam int unsigned NSF_MAX = 7;
   localparam int unsigned NSF_LCM = 420;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } occ_state_e;

   // N_SF = 4 uses a fixed phase pattern instead of (occi*m) mod N_SF
   localparam logic [0:3][0:3][2:0] PHI4_TBL = '{
      '{3'd0, 3'd0, 3'd0, 3'd0},
      '{3'd0, 3'd2, 3'd0, 3'd2},
      '{3'd0, 3'd0, 3'd2, 3'd2},
      '{3'd0, 3'd2, 3'd2, 3'd0}
   };

   function automatic int unsigned nsf_step(input int unsigned res, input logic [2:0] nsf);
      case (nsf)
         3'd1:    return res;
         3'd2:    return res / 32'd2;
         3'd3:    return res / 32'd3;
         3'd4:    return res / 32'd4;
         3'd5:    return res / 32'd5;
         3'd6:    return res / 32'd6;
         3'd7:    return res / 32'd7;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic nsf_ok(input int unsigned res, input logic [2:0] nsf);
      if (32'(nsf) > NSF_MAX) begin
         return 1'b0;
      end else begin
         case (nsf)
            3'd1:    return 1'b1;
            3'd2:    return (res % 32'd2) == 32'd0;
            3'd3:    return (res % 32'd3) == 32'd0;
            3'd4:    return (res % 32'd4) == 32'd0;
            3'd5:    return (res % 32'd5) == 32'd0;
            3'd6:    return (res % 32'd6) == 32'd0;
            3'd7:    return (res % 32'd7) == 32'd0;
            default: return 1'b0;
         endcase
      end
   endfunction

endpackage

// File: rtl/pucch1_occ_phi_gen.sv
// Per-hop element counter and modulo accumulator; presents the next element's m, phi and
// end-of-hop flag so the parent can register them on the same edge this block updates.
module pucch1_occ_phi_gen
   import pucch1_occ_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_load,
   input  logic       i_adv,
   input  logic [2:0] i_nsf,
   input  logic [2:0] i_occi,
   output logic [2:0] o_phi_d,
   output logic [2:0] o_m_d,
   output logic       o_last_d
);

   logic [2:0] m_q, m_d;
   logic [2:0] acc_q, acc_d;
   logic [3:0] acc_sum;

   // acc and occi are both below nsf, so one conditional subtract keeps acc in range
   always_comb begin
      acc_sum = {1'b0, acc_q} + {1'b0, i_occi};
      m_d     = m_q;
      acc_d   = acc_q;
      if (i_load) begin
         m_d   = 3'd0;
         acc_d = 3'd0;
      end else if (i_adv) begin
         m_d = m_q + 3'd1;
         if (acc_sum >= {1'b0, i_nsf}) begin
            acc_d = 3'(acc_sum - {1'b0, i_nsf});
         end else begin
            acc_d = acc_sum[2:0];
         end
      end else begin
         m_d   = m_q;
         acc_d = acc_q;
      end
      if (i_nsf == 3'd4) begin
         o_phi_d = PHI4_TBL[i_occi[1:0]][m_d[1:0]];
      end else begin
         o_phi_d = acc_d;
      end
      o_m_d    = m_d;
      o_last_d = (m_d == (i_nsf - 3'd1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q   <= 3'd0;
         acc_q <= 3'd0;
      end else begin
         m_q   <= m_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/pucch1_occ_phase_gen.sv
// PUCCH format 1 time-domain OCC phase sequence generator, one element per accepted request.
// Optional phase offset port enabled by defining PUCCH1_OCC_PHASE_OFS_EN.
module pucch1_occ_phase_gen
   import pucch1_occ_pkg::*;
#(
   parameter int unsigned PHASE_RES = NSF_LCM,
   parameter int unsigned PHASE_W   = $clog2(PHASE_RES)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic               i_next,
   input  logic [2:0]         i_nSF0,
   input  logic [2:0]         i_occi0,
   input  logic [2:0]         i_nSF1,
   input  logic [2:0]         i_occi1,
`ifdef PUCCH1_OCC_PHASE_OFS_EN
   input  logic [PHASE_W-1:0] i_phase_ofs,
`endif
   output logic [PHASE_W-1:0] o_wi_phi,
   output logic [2:0]         o_m,
   output logic               o_hop,
   output logic               o_last,
   output logic               o_valid,
   output logic               o_done,
   output logic               o_is_supported,
   output logic               o_busy
);

   occ_state_e         state_q;
   logic [2:0]         nsf0_q, occi0_q, nsf1_q, occi1_q;
   logic               hop_q, hop_last_q;
   logic [PHASE_W-1:0] wi_phi_q;
   logic [2:0]         m_q;
   logic               last_q, valid_q, done_q, supported_q, busy_q;

   logic               start_ok, advance;
   logic               gen_load, gen_adv, gen_last;
   logic [2:0]         gen_nsf, gen_occi, gen_phi, gen_m, nsf1_sel;
   logic               hop_d, last_d;
   logic [PHASE_W-1:0] step, phase, phi_out;
`ifdef PUCCH1_OCC_PHASE_OFS_EN
   logic [PHASE_W-1:0] ofs_q, ofs_sel;
   logic [PHASE_W:0]   phase_sum;
`endif

   pucch1_occ_phi_gen u_phi_gen (
      .clk      (clk),
      .rst      (rst),
      .i_load   (gen_load),
      .i_adv    (gen_adv),
      .i_nsf    (gen_nsf),
      .i_occi   (gen_occi),
      .o_phi_d  (gen_phi),
      .o_m_d    (gen_m),
      .o_last_d (gen_last)
   );

   // Config validation, hop sequencing and scaling of the next element's phase
   always_comb begin
      start_ok = nsf_ok(PHASE_RES, i_nSF0) && (i_occi0 < i_nSF0) &&
                 ((i_nSF1 == 3'd0) || (nsf_ok(PHASE_RES, i_nSF1) && (i_occi1 < i_nSF1)));
`ifdef PUCCH1_OCC_PHASE_OFS_EN
      start_ok = start_ok && (32'(i_phase_ofs) < PHASE_RES);
      ofs_sel  = i_start ? i_phase_ofs : ofs_q;
`endif
      advance  = (state_q == ST_RUN) && valid_q && i_next && !last_q;
      gen_load = 1'b0;
      gen_adv  = 1'b0;
      gen_nsf  = hop_q ? nsf1_q : nsf0_q;
      gen_occi = hop_q ? occi1_q : occi0_q;
      hop_d    = hop_q;
      nsf1_sel = nsf1_q;
      if (i_start) begin
         gen_load = 1'b1;
         gen_nsf  = i_nSF0;
         gen_occi = i_occi0;
         hop_d    = 1'b0;
         nsf1_sel = i_nSF1;
      end else if (advance) begin
         if (hop_last_q) begin
            gen_load = 1'b1;
            gen_nsf  = nsf1_q;
            gen_occi = occi1_q;
            hop_d    = 1'b1;
         end else begin
            gen_adv = 1'b1;
         end
      end else begin
         gen_load = 1'b0;
         gen_adv  = 1'b0;
      end
      last_d = gen_last && (hop_d || (nsf1_sel == 3'd0));
      step   = PHASE_W'(nsf_step(PHASE_RES, gen_nsf));
      phase  = PHASE_W'(32'(gen_phi) * 32'(step));
`ifdef PUCCH1_OCC_PHASE_OFS_EN
      phase_sum = {1'b0, phase} + {1'b0, ofs_sel};
      if (phase_sum >= (PHASE_W + 1)'(PHASE_RES)) begin
         phi_out = PHASE_W'(phase_sum - (PHASE_W + 1)'(PHASE_RES));
      end else begin
         phi_out = phase_sum[PHASE_W-1:0];
      end
`else
      phi_out = phase;
`endif
   end

   // Control FSM with registered outputs; i_start overrides any element consumption
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         nsf0_q      <= 3'd0;
         occi0_q     <= 3'd0;
         nsf1_q      <= 3'd0;
         occi1_q     <= 3'd0;
         hop_q       <= 1'b0;
         hop_last_q  <= 1'b0;
         wi_phi_q    <= '0;
         m_q         <= 3'd0;
         last_q      <= 1'b0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         supported_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef PUCCH1_OCC_PHASE_OFS_EN
         ofs_q       <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         if (i_start) begin
            nsf0_q      <= i_nSF0;
            occi0_q     <= i_occi0;
            nsf1_q      <= i_nSF1;
            occi1_q     <= i_occi1;
            supported_q <= start_ok;
`ifdef PUCCH1_OCC_PHASE_OFS_EN
            ofs_q       <= i_phase_ofs;
`endif
            if (start_ok) begin
               state_q    <= ST_RUN;
               valid_q    <= 1'b1;
               busy_q     <= 1'b1;
               wi_phi_q   <= phi_out;
               m_q        <= gen_m;
               hop_q      <= 1'b0;
               last_q     <= last_d;
               hop_last_q <= gen_last;
            end else begin
               state_q    <= ST_IDLE;
               valid_q    <= 1'b0;
               busy_q     <= 1'b0;
               done_q     <= 1'b1;
               wi_phi_q   <= '0;
               m_q        <= 3'd0;
               hop_q      <= 1'b0;
               last_q     <= 1'b0;
               hop_last_q <= 1'b0;
            end
         end else begin
            case (state_q)
               ST_RUN: begin
                  if (valid_q && i_next) begin
                     if (last_q) begin
                        state_q    <= ST_IDLE;
                        valid_q    <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        wi_phi_q   <= '0;
                        m_q        <= 3'd0;
                        hop_q      <= 1'b0;
                        last_q     <= 1'b0;
                        hop_last_q <= 1'b0;
                     end else begin
                        wi_phi_q   <= phi_out;
                        m_q        <= gen_m;
                        hop_q      <= hop_d;
                        last_q     <= last_d;
                        hop_last_q <= gen_last;
                     end
                  end else begin
                     state_q <= ST_RUN;
                  end
               end
               ST_IDLE: begin
                  state_q <= ST_IDLE;
               end
               default: begin
                  state_q <= ST_IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_wi_phi       = wi_phi_q;
   assign o_m            = m_q;
   assign o_hop          = hop_q;
   assign o_last         = last_q;
   assign o_valid        = valid_q;
   assign o_done         = done_q;
   assign o_is_supported = supported_q;
   assign o_busy         = busy_q;

endmodule

// File: tb/tb_pucch1_occ_phase_gen.sv
// Directed self-checking bench: PHASE_RES=420 instance plus a PHASE_RES=24 instance.
module tb_pucch1_occ_phase_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_start, i_next;
   logic [2:0] i_nSF0, i_occi0, i_nSF1, i_occi1;
   logic [8:0] o_wi_phi;
   logic [2:0] o_m;
   logic       o_hop, o_last, o_valid, o_done, o_is_supported, o_busy;
`ifdef PUCCH1_OCC_PHASE_OFS_EN
   logic [8:0] i_phase_ofs;
   logic [4:0] b_phase_ofs;
`endif

   logic       b_start, b_next;
   logic [2:0] b_nSF0, b_occi0;
   logic [4:0] b_wi_phi;
   logic [2:0] b_m;
   logic       b_hop, b_last, b_valid, b_done, b_is_supported, b_busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pucch1_occ_phase_gen dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_next(i_next),
      .i_nSF0(i_nSF0), .i_occi0(i_occi0), .i_nSF1(i_nSF1), .i_occi1(i_occi1),
`ifdef PUCCH1_OCC_PHASE_OFS_EN
      .i_phase_ofs(i_phase_ofs),
`endif
      .o_wi_phi(o_wi_phi), .o_m(o_m), .o_hop(o_hop), .o_last(o_last),
      .o_valid(o_valid), .o_done(o_done), .o_is_supported(o_is_supported), .o_busy(o_busy)
   );

   pucch1_occ_phase_gen #(.PHASE_RES(24)) dut24 (
      .clk(clk), .rst(rst), .i_start(b_start), .i_next(b_next),
      .i_nSF0(b_nSF0), .i_occi0(b_occi0), .i_nSF1(3'd0), .i_occi1(3'd0),
`ifdef PUCCH1_OCC_PHASE_OFS_EN
      .i_phase_ofs(b_phase_ofs),
`endif
      .o_wi_phi(b_wi_phi), .o_m(b_m), .o_hop(b_hop), .o_last(b_last),
      .o_valid(b_valid), .o_done(b_done), .o_is_supported(b_is_supported), .o_busy(b_busy)
   );

   task automatic do_start(input logic [2:0] n0, input logic [2:0] c0,
                           input logic [2:0] n1, input logic [2:0] c1);
      @(negedge clk);
      i_start = 1'b1; i_nSF0 = n0; i_occi0 = c0; i_nSF1 = n1; i_occi1 = c1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic b_do_start(input logic [2:0] n0, input logic [2:0] c0);
      @(negedge clk);
      b_start = 1'b1; b_nSF0 = n0; b_occi0 = c0;
      @(negedge clk);
      b_start = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++;
      if ({o_valid, o_done, o_busy, o_is_supported, o_last, o_hop, o_m, o_wi_phi} !== 17'd0) begin
         failures++;
         $display("FAIL reset_main: got %b expected all zero",
                  {o_valid, o_done, o_busy, o_is_supported, o_last, o_hop, o_m, o_wi_phi});
      end
      checks++;
      if ({b_valid, b_done, b_busy, b_is_supported, b_last, b_hop, b_m, b_wi_phi} !== 13'd0) begin
         failures++;
         $display("FAIL reset_24: got %b expected all zero",
                  {b_valid, b_done, b_busy, b_is_supported, b_last, b_hop, b_m, b_wi_phi});
      end
      rst = 1'b0;
   endtask

   task automatic test_nsf4;
      int e [4];
      e = '{0, 210, 0, 210};
      do_start(3'd4, 3'd1, 3'd0, 3'd0);
      i_next = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (o_wi_phi !== 9'(e[k])) begin
            failures++;
            $display("FAIL nsf4_phi[%0d]: got %0d expected %0d", k, o_wi_phi, e[k]);
         end
         checks++;
         if ({o_valid, o_busy, o_hop, o_m, o_last, o_done} !== {1'b1, 1'b1, 1'b0, 3'(k), (k == 3), 1'b0}) begin
            failures++;
            $display("FAIL nsf4_flags[%0d]: got v%b b%b h%b m%0d l%b d%b", k,
                     o_valid, o_busy, o_hop, o_m, o_last, o_done);
         end
         @(negedge clk);
      end
      checks++;
      if ({o_valid, o_busy, o_done} !== 3'b001) begin
         failures++;
         $display("FAIL nsf4_done: got v%b b%b d%b expected v0 b0 d1", o_valid, o_busy, o_done);
      end
      i_next = 1'b0;
      @(negedge clk);
      checks++;
      if (o_done !== 1'b0) begin
         failures++;
         $display("FAIL nsf4_done_pulse: got %b expected 0", o_done);
      end
   endtask

   task automatic test_two_hops;
      int e [14];
      e = '{0, 180, 360, 120, 300, 60, 240, 0, 360, 300, 240, 180, 120, 60};
      do_start(3'd7, 3'd3, 3'd7, 3'd6);
      i_next = 1'b1;
      for (int k = 0; k < 14; k++) begin
         checks++;
         if (o_wi_phi !== 9'(e[k])) begin
            failures++;
            $display("FAIL hops_phi[%0d]: got %0d expected %0d", k, o_wi_phi, e[k]);
         end
         checks++;
         if ({o_valid, o_hop, o_m, o_last} !== {1'b1, (k >= 7), 3'(k % 7), (k == 13)}) begin
            failures++;
            $display("FAIL hops_flags[%0d]: got v%b h%b m%0d l%b", k, o_valid, o_hop, o_m, o_last);
         end
         @(negedge clk);
      end
      checks++;
      if ({o_valid, o_done} !== 2'b01) begin
         failures++;
         $display("FAIL hops_done: got v%b d%b expected v0 d1", o_valid, o_done);
      end
      i_next = 1'b0;
   endtask

   task automatic test_stall;
      int e [3];
      e = '{0, 280, 140};
      do_start(3'd3, 3'd2, 3'd0, 3'd0);
      i_next = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({o_valid, o_m, o_last, o_wi_phi} !== {1'b1, 3'(k), (k == 2), 9'(e[k])}) begin
            failures++;
            $display("FAIL stall_elem[%0d]: got v%b m%0d l%b phi%0d expected phi%0d", k,
                     o_valid, o_m, o_last, o_wi_phi, e[k]);
         end
         @(negedge clk);
         checks++;
         if ({o_valid, o_m, o_done, o_wi_phi} !== {1'b1, 3'(k), 1'b0, 9'(e[k])}) begin
            failures++;
            $display("FAIL stall_hold[%0d]: got v%b m%0d d%b phi%0d expected phi%0d", k,
                     o_valid, o_m, o_done, o_wi_phi, e[k]);
         end
         i_next = 1'b1;
         @(negedge clk);
         i_next = 1'b0;
      end
      checks++;
      if ({o_valid, o_done} !== 2'b01) begin
         failures++;
         $display("FAIL stall_done: got v%b d%b expected v0 d1", o_valid, o_done);
      end
   endtask

   task automatic test_reject;
      do_start(3'd5, 3'd5, 3'd0, 3'd0);
      checks++;
      if ({o_is_supported, o_valid, o_busy, o_done} !== 4'b0001) begin
         failures++;
         $display("FAIL reject_occ: got s%b v%b b%b d%b expected s0 v0 b0 d1",
                  o_is_supported, o_valid, o_busy, o_done);
      end
      @(negedge clk);
      checks++;
      if ({o_valid, o_done} !== 2'b00) begin
         failures++;
         $display("FAIL reject_after: got v%b d%b expected v0 d0", o_valid, o_done);
      end
      do_start(3'd2, 3'd0, 3'd3, 3'd3);
      checks++;
      if ({o_is_supported, o_valid, o_done} !== 3'b001) begin
         failures++;
         $display("FAIL reject_hop1: got s%b v%b d%b expected s0 v0 d1", o_is_supported, o_valid, o_done);
      end
      b_do_start(3'd7, 3'd0);
      checks++;
      if ({b_is_supported, b_valid, b_done} !== 3'b001) begin
         failures++;
         $display("FAIL reject_res24_nsf7: got s%b v%b d%b expected s0 v0 d1", b_is_supported, b_valid, b_done);
      end
      b_do_start(3'd6, 3'd1);
      b_next = 1'b1;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if ({b_is_supported, b_valid, b_m, b_last, b_wi_phi} !== {1'b1, 1'b1, 3'(k), (k == 5), 5'(4 * k)}) begin
            failures++;
            $display("FAIL res24_elem[%0d]: got s%b v%b m%0d l%b phi%0d expected phi%0d", k,
                     b_is_supported, b_valid, b_m, b_last, b_wi_phi, 4 * k);
         end
         @(negedge clk);
      end
      checks++;
      if ({b_valid, b_done} !== 2'b01) begin
         failures++;
         $display("FAIL res24_done: got v%b d%b expected v0 d1", b_valid, b_done);
      end
      b_next = 1'b0;
   endtask

   task automatic test_restart;
      int dones = 0;
      do_start(3'd6, 3'd1, 3'd0, 3'd0);
      i_next = 1'b1;
      @(negedge clk);
      checks++;
      if ({o_m, o_wi_phi} !== {3'd1, 9'd70}) begin
         failures++;
         $display("FAIL restart_pre: got m%0d phi%0d expected m1 phi70", o_m, o_wi_phi);
      end
      i_start = 1'b1; i_nSF0 = 3'd2; i_occi0 = 3'd1; i_nSF1 = 3'd0; i_occi1 = 3'd0;
      @(negedge clk);
      i_start = 1'b0;
      checks++;
      if ({o_valid, o_m, o_last, o_done, o_wi_phi} !== {1'b1, 3'd0, 1'b0, 1'b0, 9'd0}) begin
         failures++;
         $display("FAIL restart_first: got v%b m%0d l%b d%b phi%0d expected v1 m0 l0 d0 phi0",
                  o_valid, o_m, o_last, o_done, o_wi_phi);
      end
      @(negedge clk);
      checks++;
      if ({o_valid, o_m, o_last, o_wi_phi} !== {1'b1, 3'd1, 1'b1, 9'd210}) begin
         failures++;
         $display("FAIL restart_second: got v%b m%0d l%b phi%0d expected v1 m1 l1 phi210",
                  o_valid, o_m, o_last, o_wi_phi);
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (o_done === 1'b1) dones++;
      end
      checks++;
      if (dones != 1) begin
         failures++;
         $display("FAIL restart_done_count: got %0d expected 1", dones);
      end
      i_next = 1'b0;
   endtask

   task automatic test_async_reset;
      int dones = 0;
      do_start(3'd7, 3'd1, 3'd0, 3'd0);
      i_next = 1'b1;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({o_valid, o_busy, o_is_supported, o_last, o_done, o_m, o_wi_phi} !== 17'd0) begin
         failures++;
         $display("FAIL async_rst: got v%b b%b s%b l%b d%b m%0d phi%0d expected all zero",
                  o_valid, o_busy, o_is_supported, o_last, o_done, o_m, o_wi_phi);
      end
      i_next = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (o_done === 1'b1 || o_valid === 1'b1) dones++;
      end
      checks++;
      if (dones != 0) begin
         failures++;
         $display("FAIL async_rst_quiet: got %0d active cycles expected 0", dones);
      end
   endtask

`ifdef PUCCH1_OCC_PHASE_OFS_EN
   task automatic test_ofs;
      i_phase_ofs = 9'd400;
      do_start(3'd2, 3'd1, 3'd0, 3'd0);
      i_phase_ofs = 9'd0;
      i_next = 1'b1;
      checks++;
      if ({o_valid, o_wi_phi} !== {1'b1, 9'd400}) begin
         failures++;
         $display("FAIL ofs_first: got v%b phi%0d expected v1 phi400", o_valid, o_wi_phi);
      end
      @(negedge clk);
      checks++;
      if ({o_valid, o_last, o_wi_phi} !== {1'b1, 1'b1, 9'd190}) begin
         failures++;
         $display("FAIL ofs_second: got v%b l%b phi%0d expected v1 l1 phi190", o_valid, o_last, o_wi_phi);
      end
      i_next = 1'b0;
      @(negedge clk);
      i_phase_ofs = 9'd420;
      do_start(3'd2, 3'd1, 3'd0, 3'd0);
      i_phase_ofs = 9'd0;
      checks++;
      if ({o_is_supported, o_valid, o_done} !== 3'b001) begin
         failures++;
         $display("FAIL ofs_reject: got s%b v%b d%b expected s0 v0 d1", o_is_supported, o_valid, o_done);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      i_start = 1'b0; i_next = 1'b0;
      i_nSF0 = 3'd0; i_occi0 = 3'd0; i_nSF1 = 3'd0; i_occi1 = 3'd0;
      b_start = 1'b0; b_next = 1'b0; b_nSF0 = 3'd0; b_occi0 = 3'd0;
`ifdef PUCCH1_OCC_PHASE_OFS_EN
      i_phase_ofs = 9'd0;
      b_phase_ofs = 5'd0;
`endif
      repeat (2) @(negedge clk);
      test_reset();
      test_nsf4();
      test_two_hops();
      test_stall();
      test_reject();
      test_restart();
      test_async_reset();
`ifdef PUCCH1_OCC_PHASE_OFS_EN
      test_ofs();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
